// File: rtl/a2d_arb_pkg.sv
// a2d_arb_pkg: shared types, widths and helpers for the A2D request arbiter.
package a2d_arb_pkg;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned CHNNL_W = 3;
    localparam int unsigned RES_W   = 12;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_CNV = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Priority pointer for the next round: the requester after the owner, wrapping 2->0.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [NREQ-1:0] owner);
        case (owner)
            3'b001:  return PTR_W'(1);
            3'b010:  return PTR_W'(2);
            default: return PTR_W'(0);
        endcase
    endfunction

    // Channel field of the requester selected by a one-hot vector.
    function automatic logic [CHNNL_W-1:0] chnnl_sel(input logic [NREQ*CHNNL_W-1:0] fields,
                                                     input logic [NREQ-1:0]         onehot);
        logic [CHNNL_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (onehot[i]) begin
                sel = sel | fields[i*CHNNL_W +: CHNNL_W];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/a2d_rr_pick.sv
// a2d_rr_pick: combinational round-robin picker; search starts at ptr and wraps 2->0.
module a2d_rr_pick
    import a2d_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // First asserted request at or after the pointer wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = PTR_W'((32'(ptr) + 32'(k)) % NREQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin arbitration of three requesters onto one shared A2D converter.
// Optional conversion timeout is enabled by defining A2D_TIMEOUT_EN.
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int unsigned TMO_CYC = 1024
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CHNNL_W-1:0] req_chnnl,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [RES_W-1:0]        res,
    output logic                    err,
    output logic                    busy,
    output logic                    start_conv,
    output logic [CHNNL_W-1:0]      chnnl,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        A2D_res
);

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [NREQ-1:0]  pick;

    a2d_rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick)
    );

    // Strobes decoded straight from the state register.
    assign start_conv = (state == START);
    assign done       = (state == DONE) ? gnt : '0;
    assign busy       = (state != IDLE);

`ifdef A2D_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit_c;

    assign tmo_hit_c = (tmo_cnt == CNT_W'(TMO_CYC - 1));
`else
    logic tmo_unused_c;

    assign tmo_unused_c = ^32'(TMO_CYC);
    assign err          = 1'b0;
`endif

    // Transaction FSM with registered grant, channel, result and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            chnnl   <= '0;
            res     <= '0;
`ifdef A2D_TIMEOUT_EN
            err     <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
`ifdef A2D_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= pick;
                        chnnl <= chnnl_sel(req_chnnl, pick);
                        state <= START;
                    end
                end
                START: begin
`ifdef A2D_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= WAIT_CNV;
                end
                WAIT_CNV: begin
                    if (cnv_cmplt) begin
                        res   <= A2D_res;
                        state <= DONE;
                    end
`ifdef A2D_TIMEOUT_EN
                    else if (tmo_hit_c) begin
                        res   <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    gnt   <= '0;
                    ptr   <= ptr_after(gnt);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: directed self-checking bench for a2d_arbiter (timeout path under A2D_TIMEOUT_EN).
module tb_a2d_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  req_chnnl;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [11:0] res;
    logic        err;
    logic        busy;
    logic        start_conv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;

    int checks = 0;
    int errors = 0;

    a2d_arbiter #(.TMO_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_chnnl  (req_chnnl),
        .gnt        (gnt),
        .done       (done),
        .res        (res),
        .err        (err),
        .busy       (busy),
        .start_conv (start_conv),
        .chnnl      (chnnl),
        .cnv_cmplt  (cnv_cmplt),
        .A2D_res    (A2D_res)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are settled and inputs may change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_chnnl = '0;
        cnv_cmplt = 1'b0;
        A2D_res   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, done, res, err, busy, start_conv, chnnl} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b done=%b res=%h err=%b busy=%b sc=%b ch=%0d, expected all 0",
                     gnt, done, res, err, busy, start_conv, chnnl);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || start_conv !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b start_conv=%b expected 0 0", busy, start_conv);
        end
    endtask

    task automatic test_single();
        int sc_cnt;
        req       = 3'b001;
        req_chnnl = 9'd5;
        tick();
        checks++;
        if (gnt !== 3'b001 || chnnl !== 3'd5 || start_conv !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start: got gnt=%b ch=%0d sc=%b busy=%b expected 001 5 1 1",
                     gnt, chnnl, start_conv, busy);
        end
        sc_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (start_conv === 1'b1) sc_cnt++;
        end
        cnv_cmplt = 1'b1;
        A2D_res   = 12'hABC;
        tick();
        if (start_conv === 1'b1) sc_cnt++;
        cnv_cmplt = 1'b0;
        A2D_res   = 12'h000;
        checks++;
        if (done !== 3'b001 || res !== 12'hABC || err !== 1'b0 || chnnl !== 3'd5) begin
            errors++;
            $display("FAIL single_done: got done=%b res=%h err=%b ch=%0d expected 001 abc 0 5",
                     done, res, err, chnnl);
        end
        checks++;
        if (sc_cnt !== 0) begin
            errors++;
            $display("FAIL single_start_once: got %0d extra start_conv pulses expected 0", sc_cnt);
        end
        req = 3'b000;
        tick();
        checks++;
        if (done !== 3'b000 || gnt !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got done=%b gnt=%b busy=%b expected 000 000 0", done, gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_gnt [4];
        logic [2:0]  exp_ch  [4];
        logic [11:0] r;
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_ch  = '{3'd2, 3'd4, 3'd6, 3'd2};
        do_reset();
        req       = 3'b111;
        req_chnnl = {3'd6, 3'd4, 3'd2};
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt[t] || chnnl !== exp_ch[t] || start_conv !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant_%0d: got gnt=%b ch=%0d sc=%b expected %b %0d 1",
                         t, gnt, chnnl, start_conv, exp_gnt[t], exp_ch[t]);
            end
            tick();
            r         = 12'h100 + 12'(t);
            cnv_cmplt = 1'b1;
            A2D_res   = r;
            tick();
            cnv_cmplt = 1'b0;
            checks++;
            if (done !== exp_gnt[t] || res !== r) begin
                errors++;
                $display("FAIL rr_done_%0d: got done=%b res=%h expected %b %h", t, done, res, exp_gnt[t], r);
            end
            tick();
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_drop();
        logic stray;
        do_reset();
        req       = 3'b010;
        req_chnnl = {3'd0, 3'd3, 3'd0};
        tick();
        tick();
        req = 3'b000;
        tick();
        checks++;
        if (gnt !== 3'b010 || busy !== 1'b1 || chnnl !== 3'd3) begin
            errors++;
            $display("FAIL drop_hold: got gnt=%b busy=%b ch=%0d expected 010 1 3", gnt, busy, chnnl);
        end
        cnv_cmplt = 1'b1;
        A2D_res   = 12'h123;
        tick();
        cnv_cmplt = 1'b0;
        checks++;
        if (done !== 3'b010 || res !== 12'h123) begin
            errors++;
            $display("FAIL drop_done: got done=%b res=%h expected 010 123", done, res);
        end
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (start_conv !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_restart: got stray activity=%b expected 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        req       = 3'b100;
        req_chnnl = {3'd7, 3'd0, 3'd0};
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({gnt, done, res, err, busy, start_conv, chnnl} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got gnt=%b done=%b res=%h err=%b busy=%b ch=%0d expected all 0",
                     gnt, done, res, err, busy, chnnl);
        end
        rst_n     = 1'b1;
        req       = 3'b000;
        cnv_cmplt = 1'b1;
        A2D_res   = 12'hFFF;
        tick();
        cnv_cmplt = 1'b0;
        checks++;
        if (done !== 3'b000 || res !== 12'h000 || busy !== 1'b0 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_cnv: got done=%b res=%h busy=%b gnt=%b expected 000 000 0 000",
                     done, res, busy, gnt);
        end
    endtask

    task automatic test_idle_cnv();
        req       = 3'b001;
        req_chnnl = 9'd1;
        tick();
        tick();
        cnv_cmplt = 1'b1;
        A2D_res   = 12'h5A5;
        tick();
        cnv_cmplt = 1'b0;
        req       = 3'b000;
        tick();
        cnv_cmplt = 1'b1;
        A2D_res   = 12'h0F0;
        tick();
        cnv_cmplt = 1'b0;
        checks++;
        if (res !== 12'h5A5 || done !== 3'b000 || busy !== 1'b0 || start_conv !== 1'b0) begin
            errors++;
            $display("FAIL idle_cnv: got res=%h done=%b busy=%b sc=%b expected 5a5 000 0 0",
                     res, done, busy, start_conv);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req       = 3'b001;
        req_chnnl = 9'd2;
        tick();
`ifdef A2D_TIMEOUT_EN
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (done !== 3'b000) break;
        end
        checks++;
        if (n !== 17 || done !== 3'b001 || err !== 1'b1 || res !== 12'h000) begin
            errors++;
            $display("FAIL timeout: got cycles=%0d done=%b err=%b res=%h expected 17 001 1 000",
                     n, done, err, res);
        end
        req = 3'b000;
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_pulse: got err=%b busy=%b expected 0 0", err, busy);
        end
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 3'b000 || busy !== 1'b1 || err !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL no_timeout_wait: got %0d bad cycles expected 0", n);
        end
        cnv_cmplt = 1'b1;
        A2D_res   = 12'h321;
        tick();
        cnv_cmplt = 1'b0;
        req       = 3'b000;
        checks++;
        if (done !== 3'b001 || res !== 12'h321 || err !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_done: got done=%b res=%h err=%b expected 001 321 0", done, res, err);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_idle_cnv();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
